// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM states and store-size codes
// (also used by DMEM and control).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] WSEL_BYTE = 2'b00;
    localparam logic [1:0] WSEL_HALF = 2'b01;
    localparam logic [1:0] WSEL_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of fetch, data and memory-macro signals around the arbiter.
// The slave view is the arbiter; the master view is the datapath plus the memory.
interface mem_arb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_kill;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [1:0]            dm_wsel;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_valid;
    logic [DATA_WIDTH-1:0] dm_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_wsel;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  dm_req, dm_we, dm_wsel, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
        output mem_req, mem_we, mem_wsel, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_kill,
        output dm_req, dm_we, dm_wsel, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
        input  mem_req, mem_we, mem_wsel, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store,
// with alternating priority on collisions and pipeline stall generation.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arb_if.slave      bus
);
    import mem_arb_pkg::*;

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_dm_q, last_dm_d;
    logic                  kill_pend_q, kill_pend_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [1:0]            mem_wsel_q, mem_wsel_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  dm_valid_q, dm_valid_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_ok;
    logic                  grant_dm;
    logic                  grant_if;

    // Collision priority flips after every data grant so streams of stores cannot starve fetch.
    always_comb begin
        if_ok    = bus.if_req & ~bus.if_kill;
        grant_dm = bus.dm_req & (~if_ok | ~last_dm_q);
        grant_if = if_ok & ~grant_dm;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        kill_pend_d = kill_pend_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wsel_d  = mem_wsel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            IDLE, RESP: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                if (grant_dm) begin
                    state_d     = DM_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_wsel_d  = bus.dm_wsel;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    last_dm_d   = 1'b1;
                end else if (grant_if) begin
                    state_d     = IF_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_wsel_d  = WSEL_WORD;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    last_dm_d   = 1'b0;
                end
            end
            IF_ACC, DM_ACC: begin
                // The memory cannot abort, so a redirect only marks the fetch as discarded.
                if (state_q == IF_ACC && bus.if_kill) begin
                    kill_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == IF_ACC) begin
                        kill_pend_d = 1'b0;
                        if (!(kill_pend_q | bus.if_kill)) begin
                            if_valid_d = 1'b1;
                            if_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b0;
            kill_pend_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wsel_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            kill_pend_q <= kill_pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wsel_q  <= mem_wsel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wsel  = mem_wsel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Stalls are combinational so the pipeline freezes in the same cycle a request appears.
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, multi-cycle corner sequences,
// and a randomized run against a transaction-timing reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int ML = 2;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10)  return 32'h00500093;
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_kill  = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_wsel  = 2'b00;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [1:0]  dm_wsel;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        int          if_lat;
        int          dm_lat;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
    } vec_t;

    vec_t vt [6];

    // Reference model state (transaction timing, counted in cycles since reset release).
    int          busy_end;
    bit          own_dm;
    bit          killed;
    bit          m_last_dm;
    logic        m_we;
    logic [1:0]  m_wsel;
    logic [31:0] m_addr, m_wdata, e_if, e_dm;

    initial begin
        idle_inputs();
        rst = 1'b0;
        #2;
        check("reset if_valid", 32'(bus.if_valid), 32'd0);
        check("reset dm_valid", 32'(bus.dm_valid), 32'd0);
        check("reset mem_req", 32'(bus.mem_req), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset if_rdata", bus.if_rdata, 32'd0);
        check("reset stall_if", 32'(bus.stall_if), 32'd0);
        tick();
        rst = 1'b1;

        // ---------------- table-driven transactions ----------------
        vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, WSEL_WORD, 32'h0,   32'h0,    3, 0, 32'h00500093,    32'h0};
        vt[1] = '{1'b1, 32'h14, 1'b1, 1'b0, WSEL_WORD, 32'h100, 32'h0,    6, 3, mem_word(32'h14), 32'hDEADBEEF};
        vt[2] = '{1'b0, 32'h0,  1'b1, 1'b1, WSEL_BYTE, 32'h3,   32'hAB,   0, 3, mem_word(32'h14), 32'hDEADBEEF};
        vt[3] = '{1'b1, 32'h18, 1'b1, 1'b0, WSEL_WORD, 32'h40,  32'h0,    3, 6, mem_word(32'h18), mem_word(32'h40)};
        vt[4] = '{1'b1, 32'h1C, 1'b1, 1'b1, WSEL_HALF, 32'h42,  32'h1234, 3, 6, mem_word(32'h1C), mem_word(32'h40)};
        vt[5] = '{1'b0, 32'h0,  1'b1, 1'b0, WSEL_WORD, 32'h80,  32'h0,    0, 3, mem_word(32'h1C), mem_word(32'h80)};

        for (int i = 0; i < 6; i++) begin
            int got_if, got_dm, n_mreq;
            got_if = 0; got_dm = 0; n_mreq = 0;
            tick();
            bus.if_req   = vt[i].if_req;
            bus.if_addr  = vt[i].if_addr;
            bus.dm_req   = vt[i].dm_req;
            bus.dm_we    = vt[i].dm_we;
            bus.dm_wsel  = vt[i].dm_wsel;
            bus.dm_addr  = vt[i].dm_addr;
            bus.dm_wdata = vt[i].dm_wdata;
            #1;
            check($sformatf("v%0d stall_if", i), 32'(bus.stall_if), 32'(vt[i].if_req));
            check($sformatf("v%0d stall_mem", i), 32'(bus.stall_mem), 32'(vt[i].dm_req));
            for (int k = 1; k <= 14; k++) begin
                tick();
                if (bus.mem_req) n_mreq++;
                if (bus.mem_req && bus.mem_we) begin
                    check($sformatf("v%0d st addr", i), bus.mem_addr, vt[i].dm_addr);
                    check($sformatf("v%0d st wsel", i), 32'(bus.mem_wsel), 32'(vt[i].dm_wsel));
                    check($sformatf("v%0d st wdata", i), bus.mem_wdata, vt[i].dm_wdata);
                end
                if (bus.if_valid) begin got_if = k; bus.if_req = 1'b0; end
                if (bus.dm_valid) begin got_dm = k; bus.dm_req = 1'b0; end
            end
            check($sformatf("v%0d if latency", i), 32'(got_if), 32'(vt[i].if_lat));
            check($sformatf("v%0d dm latency", i), 32'(got_dm), 32'(vt[i].dm_lat));
            check($sformatf("v%0d mem_req cycles", i), 32'(n_mreq),
                  32'(ML * (int'(vt[i].if_req) + int'(vt[i].dm_req))));
            check($sformatf("v%0d if_rdata", i), bus.if_rdata, vt[i].exp_if);
            check($sformatf("v%0d dm_rdata", i), bus.dm_rdata, vt[i].exp_dm);
            idle_inputs();
        end

        // ---------------- kill of an outstanding fetch ----------------
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.if_kill = (k == 1);
            if (k == 1) bus.if_addr = 32'h30;
            check($sformatf("kill k%0d if_valid", k), 32'(bus.if_valid), 32'(k == 6));
            if (k >= 3 && k < 6) check($sformatf("kill k%0d if_rdata kept", k), bus.if_rdata, mem_word(32'h1C));
            if (k == 6) check("kill refetch if_rdata", bus.if_rdata, mem_word(32'h30));
            if (k == 3) check("kill stall_if held", 32'(bus.stall_if), 32'd1);
            if (bus.if_valid) bus.if_req = 1'b0;
        end
        idle_inputs();

        // ---------------- fairness under continuous stores ----------------
        tick();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h30;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_wsel  = WSEL_WORD;
        bus.dm_addr  = 32'h200;
        bus.dm_wdata = 32'h11111111;
        for (int k = 1; k <= 9; k++) begin
            bit dm_win;
            tick();
            dm_win = (k <= 2) || (k >= 7);
            check($sformatf("fair k%0d mem_req", k), 32'(bus.mem_req), 32'((k % 3) != 0));
            if ((k % 3) != 0) begin
                check($sformatf("fair k%0d mem_we", k), 32'(bus.mem_we), 32'(dm_win));
                check($sformatf("fair k%0d mem_addr", k), bus.mem_addr,
                      dm_win ? ((k <= 2) ? 32'h200 : 32'h204) : 32'h30);
            end
            check($sformatf("fair k%0d dm_valid", k), 32'(bus.dm_valid), 32'(k == 3 || k == 9));
            check($sformatf("fair k%0d if_valid", k), 32'(bus.if_valid), 32'(k == 6));
            if (bus.dm_valid && k < 9) bus.dm_addr = 32'h204;
            if (bus.if_valid) bus.if_req = 1'b0;
        end
        idle_inputs();

        // ---------------- reset in the middle of a store ----------------
        tick();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_wsel  = WSEL_BYTE;
        bus.dm_addr  = 32'h3;
        bus.dm_wdata = 32'hAB;
        tick();
        check("rstmid mem_req before", 32'(bus.mem_req), 32'd1);
        check("rstmid mem_addr before", bus.mem_addr, 32'h3);
        #2 rst = 1'b0;
        #1;
        check("rstmid mem_req", 32'(bus.mem_req), 32'd0);
        check("rstmid mem_we", 32'(bus.mem_we), 32'd0);
        check("rstmid mem_addr", bus.mem_addr, 32'd0);
        check("rstmid mem_wdata", bus.mem_wdata, 32'd0);
        check("rstmid if_rdata", bus.if_rdata, 32'd0);
        check("rstmid dm_rdata", bus.dm_rdata, 32'd0);
        check("rstmid stall_mem", 32'(bus.stall_mem), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        begin
            int got;
            got = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (bus.dm_valid && got == 0) begin got = k; bus.dm_req = 1'b0; end
            end
            check("rstmid regrant latency", 32'(got), 32'(ML + 1));
            check("rstmid dm_rdata after store", bus.dm_rdata, 32'd0);
        end
        idle_inputs();

        // ---------------- randomized run against the reference model ----------------
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        busy_end = -1; own_dm = 1'b0; killed = 1'b0; m_last_dm = 1'b0;
        m_we = 1'b0; m_wsel = 2'b00; m_addr = '0; m_wdata = '0; e_if = '0; e_dm = '0;
        for (int c = 0; c < NRAND; c++) begin
            bit e_ifv, e_dmv, e_mreq, ifok;
            if (bus.if_valid) bus.if_req = 1'b0;
            if (bus.dm_valid) bus.dm_req = 1'b0;
            bus.if_kill = ($urandom_range(0, 11) == 0);
            if (bus.if_kill) bus.if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (bus.dm_req && $urandom_range(0, 40) == 0) begin
                bus.dm_req = 1'b0;
            end else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_wsel  = 2'($urandom_range(0, 2));
                bus.dm_addr  = 32'($urandom_range(0, 255));
                bus.dm_wdata = $urandom;
            end
            #1;
            e_ifv  = (c == busy_end) && !own_dm && !killed;
            e_dmv  = (c == busy_end) && own_dm;
            if (e_ifv) e_if = mem_word(m_addr);
            if (e_dmv && !m_we) e_dm = mem_word(m_addr);
            e_mreq = (c >= busy_end - ML) && (c < busy_end);
            check($sformatf("rnd c%0d if_valid", c), 32'(bus.if_valid), 32'(e_ifv));
            check($sformatf("rnd c%0d dm_valid", c), 32'(bus.dm_valid), 32'(e_dmv));
            check($sformatf("rnd c%0d if_rdata", c), bus.if_rdata, e_if);
            check($sformatf("rnd c%0d dm_rdata", c), bus.dm_rdata, e_dm);
            check($sformatf("rnd c%0d mem_req", c), 32'(bus.mem_req), 32'(e_mreq));
            check($sformatf("rnd c%0d mem_we", c), 32'(bus.mem_we), 32'(m_we));
            check($sformatf("rnd c%0d mem_wsel", c), 32'(bus.mem_wsel), 32'(m_wsel));
            check($sformatf("rnd c%0d mem_addr", c), bus.mem_addr, m_addr);
            check($sformatf("rnd c%0d mem_wdata", c), bus.mem_wdata, m_wdata);
            check($sformatf("rnd c%0d stall_if", c), 32'(bus.stall_if), 32'(bus.if_req & ~e_ifv));
            check($sformatf("rnd c%0d stall_mem", c), 32'(bus.stall_mem), 32'(bus.dm_req & ~e_dmv));
            if (!own_dm && e_mreq && bus.if_kill) killed = 1'b1;
            if (c >= busy_end) begin
                ifok = bus.if_req && !bus.if_kill;
                if (bus.dm_req && (!ifok || !m_last_dm)) begin
                    own_dm = 1'b1; killed = 1'b0; m_last_dm = 1'b1;
                    m_we = bus.dm_we; m_wsel = bus.dm_wsel;
                    m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                    busy_end = c + ML + 1;
                end else if (ifok) begin
                    own_dm = 1'b0; killed = 1'b0; m_last_dm = 1'b0;
                    m_we = 1'b0; m_wsel = WSEL_WORD;
                    m_addr = bus.if_addr; m_wdata = '0;
                    busy_end = c + ML + 1;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
